mmio_timer_bank: RTL and testbench
==================================

MMIO_TIMER_BANK -- requirements
Module: mmio_timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of timer channels (legal range 1..4).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h40000000, meaning the byte address of the register window.
REQ-003 The block SHALL have parameter PRESC_W, default 16, meaning the prescaler register/counter width (legal range 1..32).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rd, input, 1 bit: read strobe.
REQ-007 The block SHALL have port wr, input, 1 bit: write strobe, sampled at posedge clk.
REQ-008 The block SHALL have port addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-009 The block SHALL have port wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port rdata, output, 32 bits: read data (combinational).
REQ-011 The block SHALL have port irqout, output, 1 bit: OR of all channel IRQ flags.

Function
REQ-012 The register map SHALL be, per channel c: BASE+16c+0 TH, +4 TL, +8 TCON, +C PRESC; BASE+0x40 IRQ_STATUS; every other address (including channels >= NUM_CH) SHALL be unmapped.
REQ-013 TCON SHALL hold bit0 EN, bit1 IE, bit2 FLAG (bits [31:3] read 0, or [31:4] with REQ-027).
REQ-014 rdata SHALL equal the addressed register, zero-extended, when rd=1 and mapped, and 0 otherwise; reads SHALL have no side effects.
REQ-015 Each channel SHALL have a prescaler counter PC; with EN=1, a tick SHALL occur in a cycle where PC==PRESC, PC then reloading to 0; otherwise PC increments; PRESC=0 SHALL tick every cycle.
REQ-016 EN=0 SHALL hold PC at 0 and freeze TL.
REQ-017 On a tick with TL!=32'hFFFFFFFF, TL SHALL increment by 1; on a tick with TL==32'hFFFFFFFF, TL SHALL load TH (overflow event).
REQ-018 On an overflow with IE=1, FLAG SHALL be set at the same clock edge; with IE=0, FLAG SHALL be unchanged.
REQ-019 A TCON write SHALL load EN and IE from wdata[1:0]; wdata[2]=0 SHALL clear FLAG; wdata[2]=1 SHALL leave FLAG unchanged.
REQ-020 IRQ_STATUS SHALL read FLAG of channel c in bit c (upper bits 0); writing 1 to bit c SHALL clear that FLAG, and writing 0 SHALL have no effect.
REQ-021 A hardware FLAG set and a software clear in the same cycle SHALL leave FLAG=1.
REQ-022 A bus write to TL in the same cycle as a tick SHALL take priority; TL = wdata.
REQ-023 A PRESC write SHALL also reset that channel's PC to 0.
REQ-024 irqout SHALL be registered-flag based (OR of FLAG bits), and SHALL carry no combinational path from the bus inputs.

Reset
REQ-025 While reset=0: TH, TL, TCON, PRESC and PC of all channels SHALL be 0; irqout=0; rdata SHALL follow REQ-014 with all registers at 0.
REQ-026 An assertion of reset mid-count SHALL clear all state immediately, without waiting for a clock edge; counting SHALL resume only after software sets EN.

Configuration
REQ-027 With macro TIMER_ONESHOT_EN defined, TCON bit3 OS SHALL exist (written from wdata[3], reset 0), and an overflow with OS=1 SHALL reload TL from TH, apply REQ-018, and clear EN at the same edge; without the macro, bit3 SHALL read 0, writes to it SHALL be ignored, and timers SHALL always be periodic.

Verification
REQ-028 Scenario 1: ch0 TH=FFFFFFFD, TL=FFFFFFFD, PRESC=0, TCON=3 -> TL takes FFFFFFFE, FFFFFFFF, then FFFFFFFD; FLAG and irqout go 1 at the third edge.
REQ-029 Scenario 2: ch1 PRESC=3, TL=0, TCON=1 -> TL increments once every 4 cycles; IE=0, so FLAG stays 0 through overflow.
REQ-030 Scenario 3: with ch0 and ch1 flags set, write IRQ_STATUS=1 -> reads 2, irqout stays 1; then write 2 -> reads 0, irqout=0.
REQ-031 Scenario 4: W1C of ch0 FLAG in the same cycle as a ch0 overflow with IE=1 -> FLAG=1.
REQ-032 Scenario 5: assert reset mid-count with TL=5 -> TL=0, TCON=0 and irqout=0 before the next clk edge; a read of BASE+0x50 returns 0.
REQ-033 Scenario 6 (macro defined): TCON=0xB, TH=10, TL=FFFFFFFF -> after 1 tick TL=10, FLAG=1, EN=0, and TL holds at 10.

Source files
------------

// File: rtl/mmio_timer_bank_if.sv
// Register-bus bundle for mmio_timer_bank: read/write strobes, byte address,
// write data and combinational read data.
interface mmio_timer_bank_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, wr, addr, wdata, input  rdata);
   modport slave  (input  rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_timer_bank.sv
// Bank of NUM_CH memory-mapped reload timers with prescalers and a shared IRQ.
// Optional macro TIMER_ONESHOT_EN adds the TCON.OS one-shot bit.
module mmio_timer_ch #(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        th_we,
   input  logic        tl_we,
   input  logic        tcon_we,
   input  logic        presc_we,
   input  logic        flag_clr,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [31:0] tcon_rd,
   output logic [31:0] presc_rd,
   output logic        flag
);
   logic [PRESC_W-1:0] presc, pc;
   logic en, ie, os, tick, ovf;

   assign tick     = en && (pc == presc);
   assign ovf      = tick && (tl == 32'hFFFF_FFFF);
   assign presc_rd = 32'(presc);

`ifdef TIMER_ONESHOT_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset)       os <= 1'b0;
      else if (tcon_we) os <= wdata[3];
   assign tcon_rd = {28'd0, os, flag, ie, en};
`else
   assign os      = 1'b0;
   assign tcon_rd = {29'd0, flag, ie, en};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th    <= '0;
         tl    <= '0;
         presc <= '0;
         pc    <= '0;
         en    <= 1'b0;
         ie    <= 1'b0;
         flag  <= 1'b0;
      end else begin
         if (th_we)    th    <= wdata;
         if (presc_we) presc <= wdata[PRESC_W-1:0];
         // Bus write to TL beats a same-cycle tick.
         if (tl_we)     tl <= wdata;
         else if (tick) tl <= ovf ? th : tl + 32'd1;
         if (!en || presc_we || tick) pc <= '0;
         else                         pc <= pc + PRESC_W'(1);
         if (tcon_we)        en <= wdata[0];
         else if (ovf && os) en <= 1'b0;
         if (tcon_we) ie <= wdata[1];
         // Hardware set wins over any software clear in the same cycle.
         if (ovf && ie)                             flag <= 1'b1;
         else if ((tcon_we && !wdata[2]) || flag_clr) flag <= 1'b0;
      end
   end
endmodule

module mmio_timer_bank #(
   parameter int          NUM_CH    = 2,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          PRESC_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   mmio_timer_bank_if.slave  bus,
   output logic              irqout
);
   logic [NUM_CH-1:0][31:0] th, tl, tcon_rd, presc_rd;
   logic [NUM_CH-1:0]       flag;
   logic [29:0]             woff;
   logic                    ch_hit, irq_hit;
   logic [1:0]              ch_idx, reg_sel;
   logic                    unused_addr_bits;

   // Decode on word offsets; a wrapped (below-base) offset fails both compares.
   assign woff             = bus.addr[31:2] - BASE_ADDR[31:2];
   assign ch_hit           = woff < 30'(4 * NUM_CH);
   assign irq_hit          = woff == 30'h10;
   assign ch_idx           = woff[3:2];
   assign reg_sel          = woff[1:0];
   assign unused_addr_bits = ^bus.addr[1:0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic sel;
      assign sel = bus.wr && ch_hit && (ch_idx == 2'(c));
      mmio_timer_ch #(.PRESC_W(PRESC_W)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .th_we    (sel && reg_sel == 2'd0),
         .tl_we    (sel && reg_sel == 2'd1),
         .tcon_we  (sel && reg_sel == 2'd2),
         .presc_we (sel && reg_sel == 2'd3),
         .flag_clr (bus.wr && irq_hit && bus.wdata[c]),
         .wdata    (bus.wdata),
         .th       (th[c]),
         .tl       (tl[c]),
         .tcon_rd  (tcon_rd[c]),
         .presc_rd (presc_rd[c]),
         .flag     (flag[c])
      );
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.rd) begin
         if (irq_hit) bus.rdata = 32'(flag);
         for (int c = 0; c < NUM_CH; c++)
            if (ch_hit && ch_idx == 2'(c))
               case (reg_sel)
                  2'd0:    bus.rdata = th[c];
                  2'd1:    bus.rdata = tl[c];
                  2'd2:    bus.rdata = tcon_rd[c];
                  default: bus.rdata = presc_rd[c];
               endcase
      end
   end

   assign irqout = |flag;
endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank: register-level model checked every cycle
// plus hand-computed readback expectations for each scenario.
module tb_mmio_timer_bank;
   localparam int          NCH  = 2;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int          PW   = 16;
   localparam logic [31:0] PMSK = 32'((64'd1 << PW) - 1);

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic irqout;

   mmio_timer_bank_if bus_if();

   mmio_timer_bank #(.NUM_CH(NCH), .BASE_ADDR(BASE), .PRESC_W(PW)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if.slave),
      .irqout (irqout)
   );

   always #5 clk = ~clk;

   logic [31:0] m_th[NCH], m_tl[NCH], m_presc[NCH], m_pc[NCH];
   bit          m_en[NCH], m_ie[NCH], m_flag[NCH], m_os[NCH];
   int          n_chk = 0, n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] A(input int c, input int r);
      return BASE + 32'(16 * c + 4 * r);
   endfunction

   function automatic logic [31:0] m_tcon(input int c);
      return {28'd0, m_os[c], m_flag[c], m_ie[c], m_en[c]};
   endfunction

   function automatic logic [31:0] m_irqstat();
      logic [31:0] v = '0;
      for (int c = 0; c < NCH; c++) v[c] = m_flag[c];
      return v;
   endfunction

   function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
      logic [31:0] wa = {a[31:2], 2'b00};
      int c;
      if (!r) return '0;
      if (wa == BASE + 32'h40) return m_irqstat();
      if (wa >= BASE && wa < BASE + 32'(16 * NCH)) begin
         c = int'((wa - BASE) / 16);
         case (((wa - BASE) % 16) / 4)
            0:       return m_th[c];
            1:       return m_tl[c];
            2:       return m_tcon(c);
            default: return m_presc[c];
         endcase
      end
      return '0;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_th[c] = 0; m_tl[c] = 0; m_presc[c] = 0; m_pc[c] = 0;
         m_en[c] = 0; m_ie[c] = 0; m_flag[c] = 0; m_os[c] = 0;
      end
   endtask

   // One clock edge of the register-level behaviour, using pre-edge inputs.
   task automatic model_step();
      logic [31:0] wa, d;
      bit w_th, w_tl, w_tcon, w_presc, clr, tick, ovf;
      logic [31:0] n_tl, n_pc;
      bit n_en, n_flag;
      if (!reset) begin m_reset(); return; end
      wa = {bus_if.addr[31:2], 2'b00};
      d  = bus_if.wdata;
      for (int c = 0; c < NCH; c++) begin
         w_th    = bus_if.wr && wa == A(c, 0);
         w_tl    = bus_if.wr && wa == A(c, 1);
         w_tcon  = bus_if.wr && wa == A(c, 2);
         w_presc = bus_if.wr && wa == A(c, 3);
         clr     = bus_if.wr && wa == BASE + 32'h40 && d[c];
         tick    = m_en[c] && m_pc[c] == m_presc[c];
         ovf     = tick && m_tl[c] == 32'hFFFF_FFFF;
         n_tl    = w_tl ? d : !tick ? m_tl[c] : ovf ? m_th[c] : m_tl[c] + 1;
         n_pc    = (!m_en[c] || w_presc || tick) ? 0 : m_pc[c] + 1;
         n_en    = w_tcon ? d[0] : (ovf && m_os[c]) ? 1'b0 : m_en[c];
         n_flag  = (ovf && m_ie[c]) ? 1'b1 : ((w_tcon && !d[2]) || clr) ? 1'b0 : m_flag[c];
         m_tl[c] = n_tl; m_pc[c] = n_pc; m_en[c] = n_en; m_flag[c] = n_flag;
         if (w_th)    m_th[c] = d;
         if (w_presc) m_presc[c] = d & PMSK;
         if (w_tcon)  m_ie[c] = d[1];
`ifdef TIMER_ONESHOT_EN
         if (w_tcon)  m_os[c] = d[3];
`endif
      end
   endtask

   always @(negedge clk) begin
      check("irqout", 32'(irqout), 32'(|m_irqstat()));
      check("rdata", bus_if.rdata, m_read(bus_if.rd, bus_if.addr));
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
      cyc();
      bus_if.wr = 1'b0; bus_if.wdata = '0;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
      bus_if.rd = 1'b1; bus_if.addr = a;
      @(negedge clk);
      check(nm, bus_if.rdata, exp);
      cyc();
      bus_if.rd = 1'b0;
   endtask

   initial begin
      bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
      m_reset();
      // Reset state
      bus_if.rd = 1'b1; bus_if.addr = A(0, 2);
      idle(2);
      check("reset_irqout", 32'(irqout), 32'd0);
      check("reset_tcon0", bus_if.rdata, 32'd0);
      bus_if.rd = 1'b0;
      reset = 1'b1;
      idle(1);

      // Scenario 1: ch0 overflow with reload and IRQ
      wr_reg(A(0, 0), 32'hFFFF_FFFD);
      wr_reg(A(0, 1), 32'hFFFF_FFFD);
      wr_reg(A(0, 3), 32'd0);
      wr_reg(A(0, 2), 32'd3);
      rd_chk("s1_tl0", A(0, 1), 32'hFFFF_FFFD);
      rd_chk("s1_tl1", A(0, 1), 32'hFFFF_FFFE);
      rd_chk("s1_tl2", A(0, 1), 32'hFFFF_FFFF);
      check("s1_irqout", 32'(irqout), 32'd1);
      rd_chk("s1_tl3", A(0, 1), 32'hFFFF_FFFD);
      wr_reg(A(0, 2), 32'd4);
      rd_chk("s1_tcon", A(0, 2), 32'd4);

      // Scenario 2: ch1 prescaled by 4, IE=0
      wr_reg(A(1, 3), 32'd3);
      wr_reg(A(1, 1), 32'd0);
      wr_reg(A(1, 2), 32'd1);
      idle(3);
      rd_chk("s2_tl_pre", A(1, 1), 32'd0);
      rd_chk("s2_tl_tick", A(1, 1), 32'd1);
      rd_chk("s2_presc", A(1, 3), 32'd3);
      wr_reg(A(1, 1), 32'hFFFF_FFFF);
      idle(8);
      rd_chk("s2_noflag", A(1, 2), 32'd1);

      // Scenario 3: IRQ_STATUS write-one-to-clear
      wr_reg(A(1, 2), 32'd2);
      wr_reg(A(1, 3), 32'd0);
      wr_reg(A(1, 1), 32'hFFFF_FFFF);
      wr_reg(A(1, 2), 32'd3);
      wr_reg(A(1, 2), 32'd6);
      rd_chk("s3_stat3", BASE + 32'h40, 32'd3);
      wr_reg(BASE + 32'h40, 32'd1);
      rd_chk("s3_stat2", BASE + 32'h40, 32'd2);
      check("s3_irq1", 32'(irqout), 32'd1);
      wr_reg(BASE + 32'h40, 32'd2);
      rd_chk("s3_stat0", BASE + 32'h40, 32'd0);
      check("s3_irq0", 32'(irqout), 32'd0);

      // Scenario 4: W1C coincident with overflow leaves FLAG set
      wr_reg(A(0, 2), 32'd2);
      wr_reg(A(0, 0), 32'd0);
      wr_reg(A(0, 1), 32'hFFFF_FFFE);
      wr_reg(A(0, 2), 32'd3);
      idle(1);
      wr_reg(BASE + 32'h40, 32'd1);
      rd_chk("s4_tcon", A(0, 2), 32'd7);
      wr_reg(A(0, 2), 32'd0);

      // Unmapped and low-address-bit reads
      rd_chk("unmap_ch2", BASE + 32'h20, 32'd0);
      rd_chk("unmap_44", BASE + 32'h44, 32'd0);
      rd_chk("unmap_below", BASE - 32'd4, 32'd0);
      rd_chk("th1_lowbits", A(1, 0) + 32'd3, 32'd0);

      // Scenario 5: asynchronous reset mid-count
      wr_reg(A(1, 1), 32'hFFFF_FFFF);
      wr_reg(A(1, 2), 32'd3);
      wr_reg(A(1, 2), 32'd6);
      wr_reg(A(0, 1), 32'd0);
      wr_reg(A(0, 2), 32'd3);
      idle(5);
      bus_if.rd = 1'b1; bus_if.addr = A(0, 1);
      #1;
      check("s5_tl5", bus_if.rdata, 32'd5);
      check("s5_irq_pre", 32'(irqout), 32'd1);
      reset = 1'b0;
      m_reset();
      #1;
      check("s5_tl_rst", bus_if.rdata, 32'd0);
      check("s5_irq_rst", 32'(irqout), 32'd0);
      bus_if.addr = A(0, 2);
      #1;
      check("s5_tcon_rst", bus_if.rdata, 32'd0);
      bus_if.addr = BASE + 32'h50;
      #1;
      check("s5_unmap50", bus_if.rdata, 32'd0);
      bus_if.rd = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(3);
      rd_chk("s5_no_resume", A(0, 1), 32'd0);

`ifdef TIMER_ONESHOT_EN
      // Scenario 6: one-shot overflow disables the channel
      wr_reg(A(0, 0), 32'd10);
      wr_reg(A(0, 1), 32'hFFFF_FFFF);
      wr_reg(A(0, 3), 32'd0);
      wr_reg(A(0, 2), 32'hB);
      rd_chk("s6_tl_pre", A(0, 1), 32'hFFFF_FFFF);
      rd_chk("s6_tl_reload", A(0, 1), 32'd10);
      rd_chk("s6_tcon", A(0, 2), 32'hE);
      idle(3);
      rd_chk("s6_tl_hold", A(0, 1), 32'd10);
`else
      // OS bit absent: write to bit3 is ignored
      wr_reg(A(0, 2), 32'h8);
      rd_chk("os_absent", A(0, 2), 32'd0);
      rd_chk("tl_still0", A(0, 1), 32'd0);
`endif

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
